// File: rtl/palette_upload_pkg.sv
// Shared definitions for the palette upload engine.
//   PAL_ENTRIES       : entries per full palette image (R 0-255, G 256-511, B 512-767)
//   PAL_R/PAL_G/PAL_B : palette plane codes driven on {ah,al}
//   state_t           : upload FSM states (also exported on the debug port)
//   index_to_loc      : maps a linear entry index onto the CPU-side {ah,al,addr}
package palette_upload_pkg;

  localparam int PAL_ENTRIES = 768;

  localparam logic [1:0] PAL_R = 2'b00;
  localparam logic [1:0] PAL_G = 2'b01;
  localparam logic [1:0] PAL_B = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RDBK  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  typedef struct packed {
    logic       ah;
    logic       al;
    logic [7:0] addr;
  } pal_loc_t;

  // Plane code 2'b11 does not exist on the palette core; any index that
  // would produce it is folded onto the B plane so it can never be driven.
  function automatic pal_loc_t index_to_loc(input logic [9:0] idx);
    pal_loc_t   loc;
    logic [1:0] plane;
    case (idx[9:8])
      PAL_R:   plane = PAL_R;
      PAL_G:   plane = PAL_G;
      default: plane = PAL_B;
    endcase
    loc.ah   = plane[1];
    loc.al   = plane[0];
    loc.addr = idx[7:0];
    return loc;
  endfunction

endpackage

// File: rtl/palette_upload.sv
// Palette upload engine: copies a full palette image from work memory into
// the palette RAM through its CPU-side port, mimicking CPU write cycles.
//
// Optional feature macro: PAL_UPLOAD_READBACK_EN
//   defined     -> each WRITE is followed by a one-cycle RDBK that reads the
//                  entry back and flags the first mismatch in err/err_index.
//   not defined -> no RDBK state, pal_rd_n held high, err/err_index held 0.
//
// Ports
//   dclk, reset_n     : clock, asynchronous active-low reset
//   start, abort      : one-cycle run request (IDLE only) / cancel run
//   src_base          : source word address of entry 0, latched on start
//   busy, done        : run in progress / one-cycle completion pulse
//   mem_rd, mem_addr  : source read request and word address
//   mem_valid,mem_data: source read response (bits [4:0] used)
//   pal_cs_n, pal_wr_n, pal_rd_n, ah, al, pal_addr, pal_dout, pal_doe,
//   pal_din           : palette CPU-side bus
//   err, err_index    : sticky readback mismatch and index of the first one
//   dbg_state         : current FSM state
//
// Source handshake: mem_rd is a one-cycle request issued in FETCH; the
// engine then sits in WAIT and accepts the first mem_valid seen there.
// mem_valid in any other state is ignored and its data discarded.
module palette_upload
  import palette_upload_pkg::*;
#(
  parameter int SRC_AW  = 20,
  parameter int ENTRIES = PAL_ENTRIES
) (
  input  logic              dclk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [SRC_AW-1:0] src_base,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [SRC_AW-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [15:0]       mem_data,
  output logic              pal_cs_n,
  output logic              pal_wr_n,
  output logic              pal_rd_n,
  output logic              ah,
  output logic              al,
  output logic [7:0]        pal_addr,
  output logic [4:0]        pal_dout,
  output logic              pal_doe,
  input  logic [4:0]        pal_din,
  output logic              err,
  output logic [9:0]        err_index,
  output state_t            dbg_state
);

  localparam logic [9:0] LAST_IDX = 10'(ENTRIES - 1);

  state_t            state_q, state_d;
  logic [9:0]        index_q, index_d;
  logic [SRC_AW-1:0] base_q, base_d;
  logic [4:0]        data_q, data_d;

  logic     start_acc;
  logic     entry_end;
  logic     last_entry;
  pal_loc_t loc;

  assign start_acc  = (state_q == ST_IDLE) && start && !abort;
  assign last_entry = (index_q == LAST_IDX);

`ifdef PAL_UPLOAD_READBACK_EN
  assign entry_end = (state_q == ST_RDBK);
`else
  assign entry_end = (state_q == ST_WRITE);
`endif

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_acc) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT:  if (mem_valid) state_d = ST_WRITE;
`ifdef PAL_UPLOAD_READBACK_EN
      ST_WRITE: state_d = ST_RDBK;
      ST_RDBK:  state_d = last_entry ? ST_DONE : ST_FETCH;
`else
      ST_WRITE: state_d = last_entry ? ST_DONE : ST_FETCH;
`endif
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Datapath next values.
  always_comb begin
    index_d = index_q;
    base_d  = base_q;
    data_d  = data_q;
    if (start_acc) begin
      index_d = 10'd0;
      base_d  = src_base;
    end else if (entry_end && !abort && !last_entry) begin
      index_d = index_q + 10'd1;
    end
    if ((state_q == ST_WAIT) && mem_valid && !abort) data_d = mem_data[4:0];
  end

  always_ff @(posedge dclk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge dclk or negedge reset_n) begin
    if (!reset_n) begin
      index_q <= '0;
      base_q  <= '0;
      data_q  <= '0;
    end else begin
      index_q <= index_d;
      base_q  <= base_d;
      data_q  <= data_d;
    end
  end

`ifdef PAL_UPLOAD_READBACK_EN
  logic       err_q, err_d;
  logic [9:0] err_index_q, err_index_d;
  logic       rb_mismatch;
  logic [10:0] unused_bits;

  // pal_din reflects the entry addressed during RDBK and is taken at the
  // clock edge that ends that cycle.
  assign rb_mismatch = (state_q == ST_RDBK) && (pal_din != data_q);

  always_comb begin
    err_d       = err_q;
    err_index_d = err_index_q;
    if (start_acc) begin
      err_d       = 1'b0;
      err_index_d = '0;
    end else if (rb_mismatch) begin
      err_d = 1'b1;
      if (!err_q) err_index_d = index_q;
    end
  end

  always_ff @(posedge dclk or negedge reset_n) begin
    if (!reset_n) begin
      err_q       <= 1'b0;
      err_index_q <= '0;
    end else begin
      err_q       <= err_d;
      err_index_q <= err_index_d;
    end
  end

  assign err         = err_q;
  assign err_index   = err_index_q;
  assign pal_rd_n    = !(state_q == ST_RDBK);
  assign pal_cs_n    = !((state_q == ST_WRITE) || (state_q == ST_RDBK));
  assign unused_bits = mem_data[15:5];
`else
  logic [15:0] unused_bits;

  assign err         = 1'b0;
  assign err_index   = '0;
  assign pal_rd_n    = 1'b1;
  assign pal_cs_n    = !(state_q == ST_WRITE);
  assign unused_bits = {mem_data[15:5], pal_din};
`endif

  // All bus outputs decode directly from registered state, so an
  // asynchronous reset releases the strobes immediately.
  assign loc       = index_to_loc(index_q);
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_WAIT) ||
                     (state_q == ST_WRITE) || (state_q == ST_RDBK);
  assign done      = (state_q == ST_DONE);
  assign mem_rd    = (state_q == ST_FETCH);
  assign mem_addr  = base_q + SRC_AW'(index_q);
  assign pal_wr_n  = !(state_q == ST_WRITE);
  assign pal_doe   = (state_q == ST_WRITE);
  assign ah        = loc.ah;
  assign al        = loc.al;
  assign pal_addr  = loc.addr;
  assign pal_dout  = data_q;
  assign dbg_state = state_q;

endmodule
